// File: rtl/cover_pkg.sv
// Shared types and helpers for the coverage hit drain.
package cover_pkg;

    localparam int COVER_IDX_W = 64;
    localparam int COVER_CNT_W = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } cover_drain_state_e;

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [COVER_CNT_W-1:0] cover_sat_inc(input logic [COVER_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + COVER_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Combinational lowest-index-first priority encoder with one-hot and binary outputs.
module cover_prio_enc #(
    parameter int unsigned WIDTH = 129,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [WIDTH-1:0] onehot
);

    // lower_any[i] is set when any bit below position i is set.
    logic [WIDTH:0] lower_any;

    assign lower_any[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
            assign lower_any[gi+1] = lower_any[gi] | vec[gi];
            assign onehot[gi]      = vec[gi] & ~lower_any[gi];
        end
    endgenerate

    assign found = lower_any[WIDTH];

    // onehot has at most one bit set, so OR-ing the positions yields the index.
    always_comb begin
        index = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                index = index | IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cover_hit_drain.sv
// Latches coverage hits into a sticky pending bitmap and drains them as absolute indices.
// Define COVER_HIT_DEDUP_EN to emit each point at most once between clears/resets.
module cover_hit_drain
    import cover_pkg::*;
#(
    parameter int unsigned              WIDTH       = 129,
    parameter logic [COVER_IDX_W-1:0]   COVER_INDEX = '0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        valid,
    input  logic                    clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COVER_IDX_W-1:0]  out_index,
    output logic                    pending_any,
    output logic [COVER_CNT_W-1:0]  hit_count
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    cover_drain_state_e         state_reg;
    logic                       out_valid_reg;
    logic [COVER_IDX_W-1:0]     out_index_reg;
    logic [COVER_CNT_W-1:0]     hit_count_reg;
    logic [WIDTH-1:0]           pending_reg;
    logic [WIDTH-1:0]           pending_next;

    logic                       enc_found;
    logic [IDX_W-1:0]           enc_index;
    logic [WIDTH-1:0]           enc_onehot;

    logic                       fire;
    logic                       load;
    logic [WIDTH-1:0]           load_mask;
    logic [WIDTH-1:0]           filter;
    logic [COVER_IDX_W-1:0]     index_next;

    cover_prio_enc #(
        .WIDTH  (WIDTH)
    ) u_enc (
        .vec    (pending_reg),
        .found  (enc_found),
        .index  (enc_index),
        .onehot (enc_onehot)
    );

    assign fire       = out_valid_reg & out_ready;
    assign load       = enc_found & ((state_reg == EMPTY) | fire);
    assign load_mask  = load ? enc_onehot : '0;
    assign index_next = COVER_INDEX + COVER_IDX_W'(enc_index);

`ifdef COVER_HIT_DEDUP_EN
    logic [WIDTH-1:0] covered_reg;
    logic [WIDTH-1:0] covered_next;

    assign covered_next = covered_reg | load_mask;
    // Include the bit being loaded now, so a hit in the load cycle cannot re-arm it.
    assign filter       = covered_next;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            covered_reg <= '0;
        end else begin
            covered_reg <= covered_next;
        end
    end
`else
    assign filter = '0;
`endif

    assign pending_next = (pending_reg & ~load_mask) | (valid & ~filter);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            hit_count_reg <= '0;
            pending_reg   <= '0;
        end else begin
            pending_reg <= pending_next;
            if (fire) begin
                hit_count_reg <= cover_sat_inc(hit_count_reg);
            end
            case (state_reg)
                EMPTY: begin
                    if (load) begin
                        state_reg     <= FULL;
                        out_valid_reg <= 1'b1;
                        out_index_reg <= index_next;
                    end
                end
                FULL: begin
                    if (fire) begin
                        if (load) begin
                            out_index_reg <= index_next;
                        end else begin
                            state_reg     <= EMPTY;
                            out_valid_reg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_index   = out_index_reg;
    assign pending_any = |pending_reg;
    assign hit_count   = hit_count_reg;

endmodule

// File: tb/tb_cover_hit_drain.sv
// Directed bench for cover_hit_drain with WIDTH=129, COVER_INDEX=100.
module tb_cover_hit_drain;

    logic          clock;
    logic          reset;
    logic [128:0]  valid;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_index;
    logic          pending_any;
    logic [31:0]   hit_count;

    int n_cmp = 0;
    int n_err = 0;
    int beats = 0;
    int beats_before = 0;
    bit seen_120 = 0;

`ifdef COVER_HIT_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    cover_hit_drain #(
        .WIDTH       (129),
        .COVER_INDEX (64'd100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .valid       (valid),
        .clear       (clear),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .pending_any (pending_any),
        .hit_count   (hit_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count accepted beats away from the active edge.
    always @(negedge clock) begin
        if (reset && !clear && out_valid && out_ready) begin
            beats = beats + 1;
            if (out_index == 64'd120) seen_120 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_index", out_index, 64'd0);
        check("rst_pending_any", 64'(pending_any), 64'd0);
        check("rst_hit_count", 64'(hit_count), 64'd0);
        reset = 1'b1;
        tick();

        // 1: single hit on bit 5
        out_ready = 1'b1;
        valid[5] = 1'b1;
        tick();
        valid = '0;
        check("t1_n1_out_valid", 64'(out_valid), 64'd0);
        check("t1_n1_pending_any", 64'(pending_any), 64'd1);
        tick();
        check("t1_n2_out_valid", 64'(out_valid), 64'd1);
        check("t1_n2_out_index", out_index, 64'd105);
        check("t1_n2_pending_any", 64'(pending_any), 64'd0);
        tick();
        check("t1_n3_out_valid", 64'(out_valid), 64'd0);
        check("t1_hit_count", 64'(hit_count), 64'd1);

        // 2: ordered burst 0/64/128
        do_clear();
        check("t2_clear_count", 64'(hit_count), 64'd0);
        valid[0] = 1'b1;
        valid[64] = 1'b1;
        valid[128] = 1'b1;
        tick();
        valid = '0;
        tick();
        check("t2_b0_valid", 64'(out_valid), 64'd1);
        check("t2_b0_index", out_index, 64'd100);
        tick();
        check("t2_b1_valid", 64'(out_valid), 64'd1);
        check("t2_b1_index", out_index, 64'd164);
        tick();
        check("t2_b2_valid", 64'(out_valid), 64'd1);
        check("t2_b2_index", out_index, 64'd228);
        check("t2_pending_any", 64'(pending_any), 64'd0);
        tick();
        check("t2_end_valid", 64'(out_valid), 64'd0);
        check("t2_hit_count", 64'(hit_count), 64'd3);

        // 3: stall with bit 3 held high
        do_clear();
        out_ready = 1'b0;
        valid[3] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t3_stall_valid", 64'(out_valid), 64'd1);
            check("t3_stall_index", out_index, 64'd103);
            tick();
        end
        valid = '0;
        out_ready = 1'b1;
        tick();
        check("t3_after1_valid", 64'(out_valid), DEDUP ? 64'd0 : 64'd1);
        check("t3_after1_index", out_index, 64'd103);
        check("t3_after1_count", 64'(hit_count), 64'd1);
        tick();
        check("t3_after2_valid", 64'(out_valid), 64'd0);
        check("t3_after2_count", 64'(hit_count), DEDUP ? 64'd1 : 64'd2);

        // 4: re-hit after drain
        do_clear();
        out_ready = 1'b1;
        valid[7] = 1'b1;
        tick();
        valid = '0;
        tick();
        check("t4_first_valid", 64'(out_valid), 64'd1);
        check("t4_first_index", out_index, 64'd107);
        tick();
        check("t4_drained_valid", 64'(out_valid), 64'd0);
        tick();
        tick();
        tick();
        valid[7] = 1'b1;
        tick();
        valid = '0;
        tick();
        check("t4_second_valid", 64'(out_valid), DEDUP ? 64'd0 : 64'd1);
        check("t4_second_index", out_index, 64'd107);
        tick();
        check("t4_count", 64'(hit_count), DEDUP ? 64'd1 : 64'd2);

        // 5: clear during stall at index 110
        do_clear();
        out_ready = 1'b1;
        valid[0] = 1'b1;
        valid[1] = 1'b1;
        valid[2] = 1'b1;
        valid[3] = 1'b1;
        valid[10] = 1'b1;
        tick();
        valid = '0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        check("t5_pre_valid", 64'(out_valid), 64'd1);
        check("t5_pre_index", out_index, 64'd110);
        check("t5_pre_count", 64'(hit_count), 64'd4);
        tick();
        check("t5_hold_index", out_index, 64'd110);
        clear = 1'b1;
        valid[20] = 1'b1;
        tick();
        clear = 1'b0;
        valid = '0;
        check("t5_post_valid", 64'(out_valid), 64'd0);
        check("t5_post_pending", 64'(pending_any), 64'd0);
        check("t5_post_count", 64'(hit_count), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_120", 64'(seen_120), 64'd0);
        check("t5_idle_valid", 64'(out_valid), 64'd0);

        // 6: reset mid-stream with bits 0..9 pending
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) valid[i] = 1'b1;
        tick();
        valid = '0;
        tick();
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        check("t6_pre_pending", 64'(pending_any), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_index", out_index, 64'd0);
        check("t6_rst_pending", 64'(pending_any), 64'd0);
        check("t6_rst_count", 64'(hit_count), 64'd0);
        out_ready = 1'b1;
        beats_before = beats;
        for (int i = 0; i < 5; i++) tick();
        check("t6_idle_beats", 64'(beats), 64'(beats_before));
        check("t6_idle_valid", 64'(out_valid), 64'd0);
        valid[2] = 1'b1;
        tick();
        valid = '0;
        tick();
        check("t6_new_valid", 64'(out_valid), 64'd1);
        check("t6_new_index", out_index, 64'd102);
        tick();
        check("t6_new_count", 64'(hit_count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
